uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the CPU data bus, downstream of the processor alongside the 256-word RAM. Decodes the processor's addr_bus/mem_we/store-data, queues written bytes in a small FIFO and serialises them 8N1 on a tx pin. Exposes a readable status word so software can poll before storing; the top level muxes rd_data into the CPU's mem_data_in when io_sel is high.

---
 rtl/uart_tx_mmio.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS registers on the CPU data bus,
// a small byte FIFO and a registered serial shifter.
module uart_tx_mmio #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF00,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic        mem_we,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        io_sel,
  output logic        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [15:0]   STATUS_ADDR = BASE_ADDR + 16'd1;
  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit;
  logic            r_tx;
  logic [7:0]      r_shift;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic            r_hit_tx_q;
  logic            r_hit_st_q;

  logic            w_hit_tx;
  logic            w_hit_st;
  logic            w_acc_tx;
  logic            w_acc_st;
  logic            w_empty;
  logic            w_full;
  logic            w_busy;
  logic            w_push;
  logic            w_pop;
  logic            w_baud_end;
  logic [3:0]      w_cnt4;
  logic            w_unused_hi;

  // A held store strobe counts once: accept only on the first cycle of each hit.
  assign w_hit_tx   = mem_we && (addr_bus == BASE_ADDR);
  assign w_hit_st   = mem_we && (addr_bus == STATUS_ADDR);
  assign w_acc_tx   = w_hit_tx && !r_hit_tx_q;
  assign w_acc_st   = w_hit_st && !r_hit_st_q;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_busy     = (r_state != S_IDLE);
  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_push     = w_acc_tx && !w_full;
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end));
  assign w_cnt4     = 4'(r_count);
  assign w_unused_hi = ^wr_data[15:8];

  assign io_sel = (addr_bus == BASE_ADDR) || (addr_bus == STATUS_ADDR);
  assign tx     = r_tx;

  always_comb begin
    rd_data = 16'd0;
    if (addr_bus == STATUS_ADDR)
      rd_data = {8'd0, w_cnt4, r_ovf, w_busy, w_empty, w_full};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_tx_q <= 1'b0;
      r_hit_st_q <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_hit_tx_q <= w_hit_tx;
      r_hit_st_q <= w_hit_st;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A dropped byte on the same edge as a clear leaves the flag set.
      if (w_acc_tx && w_full) r_ovf <= 1'b1;
      else if (w_acc_st)      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (w_pop)
      r_shift <= r_mem[r_rd_ptr];
    else if ((r_state == S_DATA) && w_baud_end)
      r_shift <= {1'b0, r_shift[7:1]};
  end

  // tx is set on the same edge as the state change so every bit lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_state <= S_START;
            r_baud  <= '0;
            r_tx    <= 1'b0;
          end
        end
        S_START: begin
          if (w_baud_end) begin
            r_state <= S_DATA;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_state <= S_START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register decode, FIFO/overflow status and serial frames.
module tb_uart_tx_mmio;

  localparam int CPB  = 4;
  localparam int LOGN = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr_bus = 16'h0000;
  logic        mem_we = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic [15:0] rd_data;
  logic        io_sel;
  logic        tx;

  int checks = 0;
  int failures = 0;
  int ecnt = 0;
  logic txlog [LOGN];

  uart_tx_mmio #(.BASE_ADDR(16'hFF00), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .mem_we(mem_we),
    .wr_data(wr_data), .rd_data(rd_data), .io_sel(io_sel), .tx(tx)
  );

  always #5 clk = ~clk;

  // txlog[i] holds tx as registered by posedge number i.
  always @(posedge clk) begin
    #1;
    txlog[ecnt % LOGN] = tx;
    ecnt = ecnt + 1;
  end

  function automatic int frame_errs(input int start, input logic [7:0] b);
    logic [9:0] f;
    int n;
    f = {1'b1, b, 1'b0};
    n = 0;
    for (int k = 0; k < 10*CPB; k++)
      if (txlog[(start + k) % LOGN] !== f[k/CPB]) n++;
    return n;
  endfunction

  function automatic int low_cnt(input int start, input int len);
    int n;
    n = 0;
    for (int k = 0; k < len; k++)
      if (txlog[(start + k) % LOGN] !== 1'b1) n++;
    return n;
  endfunction

  task automatic wait_until(input int target);
    for (int i = 0; i < 2000 && ecnt < target; i++) @(negedge clk);
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d, output int s);
    @(negedge clk);
    addr_bus = a; wr_data = d; mem_we = 1'b1; s = ecnt;
    @(negedge clk);
    mem_we = 1'b0;
  endtask

  task automatic test_reset;
    addr_bus = 16'hFF01;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (rd_data !== 16'h0002) begin failures++; $display("FAIL reset_status got=%h exp=0002", rd_data); end
    checks++; if (io_sel !== 1'b1) begin failures++; $display("FAIL reset_iosel got=%b exp=1", io_sel); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rd_data !== 16'h0002) begin failures++; $display("FAIL post_reset_status got=%h exp=0002", rd_data); end
  endtask

  task automatic test_single;
    int s, e;
    @(negedge clk);
    addr_bus = 16'hFF00; wr_data = 16'h1255; mem_we = 1'b1; s = ecnt;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL single_pre_pop got=%b exp=1", tx); end
    @(negedge clk);
    mem_we = 1'b0;
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL single_latency got=%b exp=0", tx); end
    wait_until(s + 46);
    e = frame_errs(s + 1, 8'h55);
    checks++; if (e !== 0) begin failures++; $display("FAIL single_frame bad_samples=%0d exp=0", e); end
    e = low_cnt(s + 41, 5);
    checks++; if (e !== 0) begin failures++; $display("FAIL single_one_push low_samples=%0d exp=0", e); end
    addr_bus = 16'hFF01; #1;
    checks++; if (rd_data !== 16'h0002) begin failures++; $display("FAIL single_status got=%h exp=0002", rd_data); end
  endtask

  task automatic test_back_to_back;
    int s, s2, e;
    store(16'hFF00, 16'h00A5, s);
    store(16'hFF00, 16'h003C, s2);
    wait_until(s + 86);
    e = frame_errs(s + 1, 8'hA5);
    checks++; if (e !== 0) begin failures++; $display("FAIL b2b_frame1 bad_samples=%0d exp=0", e); end
    e = frame_errs(s + 41, 8'h3C);
    checks++; if (e !== 0) begin failures++; $display("FAIL b2b_frame2 bad_samples=%0d exp=0", e); end
    e = low_cnt(s + 81, 5);
    checks++; if (e !== 0) begin failures++; $display("FAIL b2b_idle_after low_samples=%0d exp=0", e); end
  endtask

  task automatic test_overflow;
    int s, t, e;
    logic [7:0] bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    store(16'hFF00, 16'h0011, s);
    store(16'hFF00, 16'h0022, t);
    store(16'hFF00, 16'h0033, t);
    store(16'hFF00, 16'h0044, t);
    store(16'hFF00, 16'h0055, t);
    store(16'hFF00, 16'h0066, t);
    addr_bus = 16'hFF01; #1;
    checks++; if (rd_data !== 16'h004D) begin failures++; $display("FAIL ovf_status got=%h exp=004D", rd_data); end
    checks++; if (io_sel !== 1'b1) begin failures++; $display("FAIL ovf_iosel got=%b exp=1", io_sel); end
    store(16'hFF01, 16'h1234, t);
    #1;
    checks++; if (rd_data !== 16'h0045) begin failures++; $display("FAIL ovf_clear got=%h exp=0045", rd_data); end
    wait_until(s + 207);
    for (int i = 0; i < 5; i++) begin
      e = frame_errs(s + 1 + 40*i, bytes[i]);
      checks++; if (e !== 0) begin failures++; $display("FAIL ovf_frame%0d bad_samples=%0d exp=0", i, e); end
    end
    e = low_cnt(s + 201, 5);
    checks++; if (e !== 0) begin failures++; $display("FAIL ovf_dropped_sent low_samples=%0d exp=0", e); end
    #1;
    checks++; if (rd_data !== 16'h0002) begin failures++; $display("FAIL ovf_drained got=%h exp=0002", rd_data); end
  endtask

  task automatic test_decode;
    int s, e;
    @(negedge clk);
    addr_bus = 16'h00FF; wr_data = 16'h0077; mem_we = 1'b1; s = ecnt; #1;
    checks++; if (io_sel !== 1'b0) begin failures++; $display("FAIL dec_00ff_iosel got=%b exp=0", io_sel); end
    checks++; if (rd_data !== 16'h0000) begin failures++; $display("FAIL dec_00ff_rd got=%h exp=0000", rd_data); end
    @(negedge clk);
    addr_bus = 16'hFF02; #1;
    checks++; if (io_sel !== 1'b0) begin failures++; $display("FAIL dec_ff02_iosel got=%b exp=0", io_sel); end
    checks++; if (rd_data !== 16'h0000) begin failures++; $display("FAIL dec_ff02_rd got=%h exp=0000", rd_data); end
    @(negedge clk);
    mem_we = 1'b0; addr_bus = 16'hFF00; #1;
    checks++; if (rd_data !== 16'h0000) begin failures++; $display("FAIL dec_txdata_rd got=%h exp=0000", rd_data); end
    checks++; if (io_sel !== 1'b1) begin failures++; $display("FAIL dec_txdata_iosel got=%b exp=1", io_sel); end
    addr_bus = 16'hFF01; #1;
    checks++; if (rd_data !== 16'h0002) begin failures++; $display("FAIL dec_status got=%h exp=0002", rd_data); end
    wait_until(s + 30);
    e = low_cnt(s, 30);
    checks++; if (e !== 0) begin failures++; $display("FAIL dec_no_frame low_samples=%0d exp=0", e); end
  endtask

  task automatic test_reset_mid_frame;
    int s, r, e;
    store(16'hFF00, 16'h00F7, s);
    wait_until(s + 19);
    checks++; if (tx !== 1'b0) begin failures++; $display("FAIL mid_bit3 got=%b exp=0", tx); end
    rst = 1'b1; addr_bus = 16'hFF01; #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("FAIL mid_reset_tx got=%b exp=1", tx); end
    checks++; if (rd_data !== 16'h0002) begin failures++; $display("FAIL mid_reset_status got=%h exp=0002", rd_data); end
    @(negedge clk); rst = 1'b0; r = ecnt;
    wait_until(r + 60);
    e = low_cnt(r, 60);
    checks++; if (e !== 0) begin failures++; $display("FAIL mid_no_resume low_samples=%0d exp=0", e); end
    #1;
    checks++; if (rd_data !== 16'h0002) begin failures++; $display("FAIL mid_final_status got=%h exp=0002", rd_data); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_decode;
    test_reset_mid_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
